// File: rtl/counter_pkg.sv
// Shared types for the up/down counter slice.
// Boundary behaviour selector used by updown_counter.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one step per DIV enabled cycles.
// Phase holds while en is low and restarts on clr or reset.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // With DIV == 1, LAST is 0 and cnt never leaves 0, so step = en.
  assign step = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter with wrap or saturate at 0 and MAX.
// tc pulses one cycle per boundary step; ovf is sticky until clr.
module updown_counter
  import counter_pkg::*;
#(
  parameter int          N    = 8,
  parameter int          MAX  = 2**N - 1,
  parameter int          DIV  = 1,
  parameter count_mode_e MODE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf,
  output logic         zero
);

  localparam logic [N-1:0] MAXV = N'(MAX);

  logic         step;
  logic [N-1:0] lv_sat;
  logic         at_top;
  logic         at_bot;

  tick_prescaler #(
    .DIV (DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr | load),
    .step (step)
  );

  assign lv_sat = (load_val > MAXV) ? MAXV : load_val;
  assign at_top = (count == MAXV);
  assign at_bot = (count == '0);
  assign zero   = at_bot;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= lv_sat;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (step) begin
        if (up) begin
          if (at_top) begin
            tc    <= 1'b1;
            ovf   <= 1'b1;
            count <= (MODE == MODE_WRAP) ? '0 : MAXV;
          end else begin
            count <= count + N'(1);
          end
        end else begin
          if (at_bot) begin
            tc    <= 1'b1;
            ovf   <= 1'b1;
            count <= (MODE == MODE_WRAP) ? MAXV : '0;
          end else begin
            count <= count - N'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: wrap, saturate, load, prescale, reset.
module tb_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [3:0] load_val;

  logic [3:0] cw, cs, cd;
  logic       tcw, tcs, tcd;
  logic       ovw, ovs, ovd;
  logic       zw, zs, zd;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  updown_counter #(.N(4), .MAX(9), .DIV(1), .MODE(MODE_WRAP)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cw), .tc(tcw), .ovf(ovw), .zero(zw)
  );

  updown_counter #(.N(4), .MAX(9), .DIV(1), .MODE(MODE_SAT)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cs), .tc(tcs), .ovf(ovs), .zero(zs)
  );

  updown_counter #(.N(4), .MAX(9), .DIV(3), .MODE(MODE_WRAP)) dut_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cd), .tc(tcd), .ovf(ovd), .zero(zd)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    clr = 1'b0; load = 1'b1; load_val = 4'd5;
    cyc();
    cyc();
    vecs++;
    if (cw !== 4'd0) begin
      errs++; $display("FAIL reset_count got %0d want 0", cw);
    end
    vecs++;
    if (tcw !== 1'b0 || ovw !== 1'b0) begin
      errs++; $display("FAIL reset_flags got tc=%b ovf=%b want 0 0", tcw, ovw);
    end
    vecs++;
    if (zw !== 1'b1) begin
      errs++; $display("FAIL reset_zero got %b want 1", zw);
    end
    vecs++;
    if (cd !== 4'd0 || cs !== 4'd0) begin
      errs++; $display("FAIL reset_others got d=%0d s=%0d want 0 0", cd, cs);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp;
    rst = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      exp = 4'(i % 10);
      vecs++;
      if (cw !== exp || tcw !== (i == 10)) begin
        errs++;
        $display("FAIL wrap_step%0d got count=%0d tc=%b want %0d %b",
                 i, cw, tcw, exp, (i == 10));
      end
    end
    vecs++;
    if (ovw !== 1'b1) begin
      errs++; $display("FAIL wrap_ovf got %b want 1", ovw);
    end
    vecs++;
    if (cs !== 4'd9 || tcs !== 1'b1 || ovs !== 1'b1) begin
      errs++;
      $display("FAIL sat_top got count=%0d tc=%b ovf=%b want 9 1 1",
               cs, tcs, ovs);
    end
    en = 1'b0;
    cyc();
    vecs++;
    if (tcw !== 1'b0 || cw !== 4'd0) begin
      errs++; $display("FAIL wrap_idle got count=%0d tc=%b want 0 0", cw, tcw);
    end
  endtask

  task automatic test_sat_down();
    logic [3:0] ec [4];
    logic       et [4];
    ec = '{4'd1, 4'd0, 4'd0, 4'd0};
    et = '{1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 4'd2; en = 1'b0;
    cyc();
    vecs++;
    if (cs !== 4'd2) begin
      errs++; $display("FAIL sat_load got %0d want 2", cs);
    end
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++;
      if (cs !== ec[i] || tcs !== et[i]) begin
        errs++;
        $display("FAIL sat_down%0d got count=%0d tc=%b want %0d %b",
                 i, cs, tcs, ec[i], et[i]);
      end
    end
    vecs++;
    if (zs !== 1'b1 || ovs !== 1'b1) begin
      errs++; $display("FAIL sat_zero got zero=%b ovf=%b want 1 1", zs, ovs);
    end
  endtask

  task automatic test_load_clamp();
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    cyc();
    vecs++;
    if (cw !== 4'd9 || tcw !== 1'b0) begin
      errs++; $display("FAIL load_clamp got count=%0d tc=%b want 9 0", cw, tcw);
    end
    vecs++;
    if (ovw !== 1'b1) begin
      errs++; $display("FAIL load_keeps_ovf got %b want 1", ovw);
    end
    clr = 1'b1; load_val = 4'd5;
    cyc();
    vecs++;
    if (cw !== 4'd0 || ovw !== 1'b0) begin
      errs++; $display("FAIL clr_over_load got count=%0d ovf=%b want 0 0", cw, ovw);
    end
    clr = 1'b0;
    cyc();
    vecs++;
    if (cw !== 4'd5) begin
      errs++; $display("FAIL load_inrange got %0d want 5", cw);
    end
  endtask

  task automatic test_prescale();
    logic [3:0] exp;
    load = 1'b0; clr = 1'b1; en = 1'b0;
    cyc();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp = 4'(k / 3);
      vecs++;
      if (cd !== exp) begin
        errs++; $display("FAIL div_en%0d got %0d want %0d", k, cd, exp);
      end
    end
    en = 1'b0;
    cyc();
    cyc();
    vecs++;
    if (cd !== 4'd2) begin
      errs++; $display("FAIL div_hold got %0d want 2", cd);
    end
    en = 1'b1;
    cyc();
    vecs++;
    if (cd !== 4'd2) begin
      errs++; $display("FAIL div_resume1 got %0d want 2", cd);
    end
    cyc();
    vecs++;
    if (cd !== 4'd3) begin
      errs++; $display("FAIL div_resume2 got %0d want 3", cd);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0; en = 1'b1; up = 1'b1;
    cyc();
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    cyc();
    vecs++;
    if (cd !== 4'd7 || ovw !== 1'b1) begin
      errs++; $display("FAIL mid_setup got d=%0d ovf_w=%b want 7 1", cd, ovw);
    end
    rst = 1'b0; load = 1'b1; clr = 1'b0;
    cyc();
    vecs++;
    if (cd !== 4'd0 || tcd !== 1'b0 || ovw !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset got d=%0d tc=%b ovf_w=%b want 0 0 0",
               cd, tcd, ovw);
    end
    rst = 1'b1; load = 1'b0;
    cyc();
    vecs++;
    if (cd !== 4'd0 || cw !== 4'd1) begin
      errs++; $display("FAIL rel1 got d=%0d w=%0d want 0 1", cd, cw);
    end
    cyc();
    vecs++;
    if (cd !== 4'd0) begin
      errs++; $display("FAIL rel2 got %0d want 0", cd);
    end
    cyc();
    vecs++;
    if (cd !== 4'd1) begin
      errs++; $display("FAIL rel3 got %0d want 1", cd);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_prescale();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
